// File: rtl/serial_adder_scheduler.sv
// serial_adder_scheduler: round-robin arbiter in front of one shared bit-serial full adder.
// A granted request is added LSB first, one bit per clk, and returned as {carry_out, sum} with its id.
module serial_adder_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_sum,
    output logic             rsp_id,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_id;
    logic             r_last_grant;

    logic             w_any;
    logic             w_grant;
    logic             w_accept;
    logic             w_sbit;
    logic             w_cout;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_next_sum;

    // On a tie the requester that did not win last time is granted.
    assign w_any      = req0_valid | req1_valid;
    assign w_grant    = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept   = resetn & (r_state == IDLE) & w_any;
    assign req0_ready = w_accept & ~w_grant;
    assign req1_ready = w_accept & w_grant;
    assign busy       = r_state != IDLE;

    assign w_sbit     = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last_bit = r_cnt == CW'(WIDTH - 1);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
    assign w_next_sum = WIDTH'({w_sbit, r_sum} >> 1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_sum      <= '0;
            rsp_id       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant ? req1_a : req0_a;
                        r_b          <= w_grant ? req1_b : req0_b;
                        r_carry      <= w_grant ? req1_cin : req0_cin;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                        r_sum        <= '0;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_sum   <= w_next_sum;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last_bit) begin
                        rsp_sum   <= {w_cout, w_next_sum};
                        rsp_id    <= r_id;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
